ifetch_prefetch: RTL
====================

# ifetch_prefetch

Instruction fetch front end with a small prefetch FIFO. It acts as master on the instruction bus, which is the read-only port of the dual-port memory, and fetches sequential 32-bit words from a program counter. The fetched instructions are buffered and handed to decode through a valid/ready handshake. A redirect input, used for branches, jumps and traps, flushes the buffer and restarts fetch at a new address.

## Interface

Parameters:
- `DEPTH`, default 4: prefetch FIFO entries; power of two, minimum 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word aligned.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `ibus`  master_bus_if.master  —  instruction bus.
  - Block drives `addr`, `ss`, `ttype`, `tsize` and `wdata`.
  - Block samples `rdata` and `bdone`.
- `redirect`  input  1  flush and restart fetch; single-cycle pulse or level.
- `redirect_pc`  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- `instr`  output  32  instruction at the FIFO head.
- `instr_pc`  output  32  address of `instr`.
- `instr_valid`  output  1  FIFO non-empty.
- `instr_ready`  input  1  decode consumes the head when `instr_valid` and `instr_ready` are both high.

## Operation

State:
- `fetch_pc[31:0]`: next address to request.
- FIFO of `DEPTH` entries, each holding {pc, instr}.
- Read pointer and write pointer, each log2(DEPTH) bits and wrapping naturally.
- `count`, 0..DEPTH.

Bus request:
- `ibus.ss` = `!redirect && count < DEPTH`.
- `ibus.addr` = `fetch_pc`.
- `ibus.ttype` = READ.
- `ibus.tsize` = WORD.
- `ibus.wdata` = 0.
- Only one request is in flight at a time. `ss`, `addr`, `ttype` and `tsize` hold steady until `bdone` is high in a cycle where `ss` is high.

Accepting a response (push):
- Condition: `ss && bdone` at a clock edge.
- Write {`fetch_pc`, `ibus.rdata`} at the write pointer, advance the write pointer, and set `fetch_pc` to `fetch_pc + 4`.
- The addition wraps modulo 2^32: 32'hFFFF_FFFC is followed by 32'h0000_0000.

Consuming an instruction (pop):
- Condition: `instr_valid && instr_ready`. The read pointer advances.
- `instr` and `instr_pc` always show the entry at the read pointer. Their value while `instr_valid` is low is don't-care.

Count update:
- `count` +1 on push only, -1 on pop only, unchanged when push and pop happen in the same cycle.
- No push can occur at `count == DEPTH` because `ss` is low, so there is no overflow.
- No pop can occur at `count == 0` because `instr_valid` is low, so there is no underflow.

Redirect has priority over everything else:
- The edge with `redirect` high sets both pointers and `count` to 0 and loads `fetch_pc` with {`redirect_pc[31:2]`, 2'b00}.
- `ss` is forced low during the redirect cycle, so any `rdata` on the bus in that cycle is discarded.
- A pop in the same cycle is also discarded; decode must treat the flushed instruction as killed.
- If `redirect` stays high for several cycles, the last `redirect_pc` value wins.

Reset:
- `rst` high clears the pointers and `count` and sets `fetch_pc` to `RESET_PC` immediately, without waiting for a clock edge.
- Outputs while in reset: `ss` = 1 once `rst` is released (`count` is 0), `instr_valid` = 0, `addr` = `RESET_PC`, `instr` and `instr_pc` don't-care.
- While `rst` is high, `ss` is forced to 0.
- Asserting `rst` mid-transfer abandons the transfer. No partial state survives.

## Timing

- Request-to-valid latency: 1 cycle. With a same-cycle `bdone`, a word requested in cycle N appears with `instr_valid` high in cycle N+1.
- Steady-state throughput: 1 instruction per cycle when decode holds `instr_ready` high and the bus returns `bdone` every cycle.
- Slow bus: `ss` stays asserted with constant `addr` for every cycle `bdone` is low. Nothing is pushed during those cycles.
- Redirect-to-first-request: the request at the new address is issued in the cycle after `redirect`. `instr_valid` for the new target rises 2 cycles after `redirect`, assuming a 1-cycle bus.
- Full FIFO: `ss` drops in the cycle where `count == DEPTH`. It reasserts in the cycle after the pop that brings `count` to DEPTH-1; `count` is registered, so there is no combinational path from `instr_ready` to `ss`.
- Combinational paths:
  - `redirect` to `ibus.ss`.
  - From `rst`, through the asynchronous clear.
  - There is no path from `ibus.rdata` to any output.

## Test plan

- Reset with `RESET_PC` = 32'h100 and `bdone` tied 1, `instr_ready` = 1, memory words = address ^ 32'hA5A5_0000. Required: the `addr` sequence is 100, 104, 108, …. The first `instr_valid` comes 1 cycle after reset release, with `instr_pc` = 100 and `instr` = 32'hA5A5_0100.
- `instr_ready` = 0 with `DEPTH` = 4. Required: exactly 4 pushes, then `ss` = 0 with `count` = 4. Raising `instr_ready` drains entries 100, 104, 108, 10C in order, and `ss` reasserts at `addr` = 110.
- Pulse `redirect` with `redirect_pc` = 32'h203 while the FIFO holds 3 entries and a transfer is in flight. Required: in the next cycle `count` = 0 and `ss` = 1 with `addr` = 200. The first valid instruction has `instr_pc` = 200, and no stale word from the old stream appears.
- `bdone` low for 3 cycles, then high. Required: `ss` and `addr` stay constant for 4 cycles, exactly one push occurs, and `fetch_pc` advances by 4 only.
- Set `fetch_pc` to FFFF_FFF8 by redirect, with `instr_ready` = 1. Required: fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` asynchronously mid-cycle while `count` = 2. Required: `instr_valid` drops and `addr` = `RESET_PC` before the next clock edge. After release, fetch restarts from `RESET_PC`.

Source files
------------

// File: rtl/master_bus_if.sv
// Master-side bus bundle shared by the fetch unit and its memory port.
// The master drives the request, the slave returns rdata and bdone.
package master_bus_pkg;
    typedef enum logic {
        BUS_READ  = 1'b0,
        BUS_WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } tsize_e;
endpackage

interface master_bus_if;
    import master_bus_pkg::*;

    logic [31:0] addr;
    logic        ss;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport master (
        output addr, ss, ttype, tsize, wdata,
        input  rdata, bdone
    );

    modport slave (
        input  addr, ss, ttype, tsize, wdata,
        output rdata, bdone
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction fetch with a small prefetch FIFO.
// Redirect flushes the buffer and restarts fetch at a new address.
module ifetch_prefetch
    import master_bus_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    master_bus_if.master ibus,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] count_q, count_d;

    logic [31:0] pc_mem [DEPTH];
    logic [31:0] ins_mem [DEPTH];

    logic push;
    logic pop;

    assign ibus.ss    = !rst && !redirect && (count_q < FULL);
    assign ibus.addr  = fetch_pc_q;
    assign ibus.ttype = BUS_READ;
    assign ibus.tsize = SZ_WORD;
    assign ibus.wdata = '0;

    assign instr_valid = (count_q != '0);
    assign instr       = ins_mem[rd_ptr_q];
    assign instr_pc    = pc_mem[rd_ptr_q];

    assign push = ibus.ss && ibus.bdone;
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= ibus.rdata;
        end
    end

endmodule
